mem_axi_responder: RTL and testbench

- Synthesizable memory-side responder for the L2's AXI-like memory port.
- Accepts AR/AW/W requests from the L2 and returns R data beats and B write responses from an internal word-addressed array.
- Used as the backing-memory model in L2 simulation and as a simple on-chip memory target.
- Read and write channels run independent FSMs, with one outstanding read and one outstanding write at a time.

---
 rtl/mem_axi_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_axi_responder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_responder.sv
// Word-addressed memory target for the L2 AXI-like port: independent read and write FSMs,
// one outstanding burst per direction, SLVERR for out-of-range beats or mis-placed w_last.
module mem_axi_responder #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned READ_LAT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ar_valid,
    output logic                ar_ready,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic [ID_W-1:0]     ar_id,
    input  logic [3:0]          ar_len,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [DATA_W-1:0]   r_data,
    output logic [ID_W-1:0]     r_id,
    output logic [1:0]          r_resp,
    output logic                r_last,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [ID_W-1:0]     aw_id,
    input  logic [3:0]          aw_len,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_last,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [ID_W-1:0]     b_id,
    output logic [1:0]          b_resp
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned OffW  = $clog2(StrbW);
    localparam int unsigned IdxW  = ADDR_W + 1;
    localparam int unsigned MemAw = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CntW  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [IdxW-1:0] DepthIdx = IdxW'(MEM_DEPTH);
    localparam logic [CntW-1:0] LatLoad  = CntW'(READ_LAT - 1);

    typedef enum logic [1:0] {RdIdle, RdWait, RdSend} rd_state_e;
    typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    rd_state_e         rd_state_q, rd_state_d;
    logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
    logic [ID_W-1:0]   rd_id_q, rd_id_d;
    logic [3:0]        rd_len_q, rd_len_d;
    logic [3:0]        rd_beat_q, rd_beat_d;
    logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              r_err_q, r_err_d;
    logic [IdxW-1:0]   fetch_idx;
    logic              fetch_ok;
    logic [DATA_W-1:0] fetch_data;

    wr_state_e         wr_state_q, wr_state_d;
    logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
    logic [ID_W-1:0]   wr_id_q, wr_id_d;
    logic [3:0]        wr_len_q, wr_len_d;
    logic [4:0]        wr_beat_q, wr_beat_d;
    logic              wr_err_q, wr_err_d;
    logic              wr_ok;
    logic              mem_we;

    // Holds both ready outputs low during the reset cycle itself.
    logic              ready_q;

    // Data is registered when a beat is fetched, so it stays stable under backpressure and a
    // same-edge write is seen only by later fetches.
    always_comb begin
        fetch_idx  = (rd_state_q == RdSend) ? rd_idx_q + 1'b1 : rd_idx_q;
        fetch_ok   = fetch_idx < DepthIdx;
        fetch_data = fetch_ok ? mem_q[fetch_idx[MemAw-1:0]] : '0;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_id_d    = rd_id_q;
        rd_len_d   = rd_len_q;
        rd_beat_d  = rd_beat_q;
        rd_cnt_d   = rd_cnt_q;
        r_data_d   = r_data_q;
        r_err_d    = r_err_q;
        ar_ready   = (rd_state_q == RdIdle) && ready_q;
        r_valid    = (rd_state_q == RdSend);
        r_last     = r_valid && (rd_beat_q == rd_len_q);
        r_data     = r_valid ? r_data_q : '0;
        r_id       = r_valid ? rd_id_q : '0;
        r_resp     = (r_valid && r_err_q) ? 2'b10 : 2'b00;
        unique case (rd_state_q)
            RdIdle: begin
                if (ar_valid && ar_ready) begin
                    rd_idx_d   = {1'b0, ar_addr} >> OffW;
                    rd_id_d    = ar_id;
                    rd_len_d   = ar_len;
                    rd_beat_d  = '0;
                    rd_cnt_d   = LatLoad;
                    rd_state_d = RdWait;
                end
            end
            RdWait: begin
                if (rd_cnt_q == '0) begin
                    r_data_d   = fetch_data;
                    r_err_d    = !fetch_ok;
                    rd_state_d = RdSend;
                end else begin
                    rd_cnt_d = rd_cnt_q - 1'b1;
                end
            end
            RdSend: begin
                if (r_ready) begin
                    if (rd_beat_q == rd_len_q) begin
                        rd_state_d = RdIdle;
                    end else begin
                        rd_beat_d = rd_beat_q + 1'b1;
                        rd_idx_d  = fetch_idx;
                        r_data_d  = fetch_data;
                        r_err_d   = !fetch_ok;
                    end
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_id_d    = wr_id_q;
        wr_len_d   = wr_len_q;
        wr_beat_d  = wr_beat_q;
        wr_err_d   = wr_err_q;
        wr_ok      = wr_idx_q < DepthIdx;
        mem_we     = 1'b0;
        aw_ready   = (wr_state_q == WrIdle) && ready_q;
        w_ready    = (wr_state_q == WrData);
        b_valid    = (wr_state_q == WrResp);
        b_id       = b_valid ? wr_id_q : '0;
        b_resp     = (b_valid && wr_err_q) ? 2'b10 : 2'b00;
        unique case (wr_state_q)
            WrIdle: begin
                if (aw_valid && aw_ready) begin
                    wr_idx_d   = {1'b0, aw_addr} >> OffW;
                    wr_id_d    = aw_id;
                    wr_len_d   = aw_len;
                    wr_beat_d  = '0;
                    wr_err_d   = 1'b0;
                    wr_state_d = WrData;
                end
            end
            WrData: begin
                if (w_valid) begin
                    mem_we    = wr_ok && rst;
                    wr_err_d  = wr_err_q || !wr_ok || (w_last != (wr_beat_q == {1'b0, wr_len_q}));
                    wr_idx_d  = wr_idx_q + 1'b1;
                    // Saturate so an overlong burst never aliases back onto len.
                    wr_beat_d = (wr_beat_q == 5'd31) ? wr_beat_q : wr_beat_q + 1'b1;
                    if (w_last) wr_state_d = WrResp;
                end
            end
            WrResp: begin
                if (b_ready) wr_state_d = WrIdle;
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state_q <= RdIdle;
            rd_idx_q   <= '0;
            rd_id_q    <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_cnt_q   <= '0;
            r_data_q   <= '0;
            r_err_q    <= 1'b0;
            wr_state_q <= WrIdle;
            wr_idx_q   <= '0;
            wr_id_q    <= '0;
            wr_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_err_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_id_q    <= rd_id_d;
            rd_len_q   <= rd_len_d;
            rd_beat_q  <= rd_beat_d;
            rd_cnt_q   <= rd_cnt_d;
            r_data_q   <= r_data_d;
            r_err_q    <= r_err_d;
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_id_q    <= wr_id_d;
            wr_len_q   <= wr_len_d;
            wr_beat_q  <= wr_beat_d;
            wr_err_q   <= wr_err_d;
            ready_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < StrbW; i++) begin
                if (w_strb[i]) mem_q[wr_idx_q[MemAw-1:0]][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_axi_responder.sv
// Randomized self-checking bench for mem_axi_responder against an array-based memory model.
module tb_mem_axi_responder;

    localparam int Depth = 1024;
    localparam int Lat   = 4;

    logic        clk, rst;
    logic        ar_valid, ar_ready, r_valid, r_ready, r_last;
    logic [31:0] ar_addr, aw_addr;
    logic [3:0]  ar_id, ar_len, r_id, aw_id, aw_len, b_id;
    logic [63:0] r_data, w_data;
    logic [1:0]  r_resp, b_resp;
    logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic [7:0]  w_strb;

    int total = 0;
    int bad   = 0;

    logic [63:0] ref_mem [Depth];
    logic [63:0] wbuf_data [20];
    logic [7:0]  wbuf_strb [20];
    logic [63:0] rbuf_data [16];
    logic [1:0]  rbuf_resp [16];
    logic        rbuf_last [16];
    logic [3:0]  rbuf_id   [16];

    mem_axi_responder #(
        .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_DEPTH(Depth), .READ_LAT(Lat)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
        .ar_len(ar_len),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_resp(r_resp),
        .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
        .aw_len(aw_len),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one write burst (w_last on beat nbeats-1) and applies in-range beats to the model.
    task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                             input int nbeats, output logic [1:0] bresp, output logic [3:0] bid,
                             output bit tmo);
        int g;
        int idx;
        tmo = 0;
        aw_valid = 1; aw_addr = addr; aw_id = id; aw_len = len;
        g = 0;
        while (!aw_ready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) tmo = 1;
        @(negedge clk);
        aw_valid = 0;
        for (int k = 0; k < nbeats; k++) begin
            w_valid = 1; w_data = wbuf_data[k]; w_strb = wbuf_strb[k]; w_last = (k == nbeats - 1);
            g = 0;
            while (!w_ready && g < 100) begin @(negedge clk); g++; end
            if (g >= 100) tmo = 1;
            @(negedge clk);
            idx = int'(addr >> 3) + k;
            if (idx < Depth) begin
                for (int j = 0; j < 8; j++)
                    if (wbuf_strb[k][j]) ref_mem[idx][8*j +: 8] = wbuf_data[k][8*j +: 8];
            end
        end
        w_valid = 0; w_last = 0;
        b_ready = 1;
        g = 0;
        while (!b_valid && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) tmo = 1;
        bresp = b_resp; bid = b_id;
        @(negedge clk);
        b_ready = 0;
    endtask

    // mode 0: always ready, 1: ready toggles 1,0,1,0..., 2: random ready.
    task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                            input int mode, output int nrx, output int lat, output bit stable,
                            output bit arlow, output bit tmo);
        int g;
        bit tog, held, done, rdy;
        logic [63:0] pd;
        logic [1:0] pr;
        logic pl;
        logic [3:0] pi;
        tmo = 0; nrx = 0; stable = 1; arlow = 1;
        ar_valid = 1; ar_addr = addr; ar_id = id; ar_len = len;
        g = 0;
        while (!ar_ready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) tmo = 1;
        @(negedge clk);
        ar_valid = 0;
        lat = 0; g = 0;
        while (!r_valid && g < 100) begin
            if (ar_ready) arlow = 0;
            @(negedge clk); lat++; g++;
        end
        tog = 1; held = 0; done = 0; g = 0;
        pd = '0; pr = '0; pl = 0; pi = '0;
        while (!done && g < 300) begin
            if (ar_ready) arlow = 0;
            if (r_valid) begin
                if (held && (r_data !== pd || r_resp !== pr || r_last !== pl || r_id !== pi))
                    stable = 0;
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
                tog = !tog;
                r_ready = rdy;
                if (rdy) begin
                    if (nrx < 16) begin
                        rbuf_data[nrx] = r_data; rbuf_resp[nrx] = r_resp;
                        rbuf_last[nrx] = r_last; rbuf_id[nrx] = r_id;
                    end
                    nrx++;
                    if (r_last) done = 1;
                end
                held = !rdy; pd = r_data; pr = r_resp; pl = r_last; pi = r_id;
            end else begin
                r_ready = 0; held = 0;
            end
            @(negedge clk); g++;
        end
        r_ready = 0;
        if (!done) tmo = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({ar_ready, aw_ready, w_ready, r_valid, b_valid, r_last, r_resp, b_resp, r_id, b_id,
             r_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ar_ready=%b aw_ready=%b w_ready=%b r_valid=%b b_valid=%b r_data=%h want all 0",
                     ar_ready, aw_ready, w_ready, r_valid, b_valid, r_data);
        end
        rst = 1;
        @(negedge clk);
        total++;
        if (ar_ready !== 1'b1 || aw_ready !== 1'b1 || w_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ar_ready=%b aw_ready=%b w_ready=%b want 1 1 0",
                     ar_ready, aw_ready, w_ready);
        end
    endtask

    task automatic test_init();
        logic [1:0] br; logic [3:0] bi; bit tmo;
        int bases [5] = '{0, 16, 32, 48, 1008};
        foreach (bases[n]) begin
            for (int k = 0; k < 16; k++) begin
                wbuf_data[k] = {$urandom, $urandom}; wbuf_strb[k] = 8'hFF;
            end
            axi_write(32'(bases[n] * 8), 4'(n), 4'd15, 16, br, bi, tmo);
            total++;
            if (tmo || br !== 2'b00 || bi !== 4'(n)) begin
                bad++;
                $display("FAIL init_write: tmo=%0d bresp=%b bid=%0d want 0 00 %0d", tmo, br, bi, n);
            end
        end
    endtask

    task automatic test_write_read();
        logic [1:0] br; logic [3:0] bi; bit tmo, st, al; int nrx, lat;
        wbuf_data[0] = 64'h1122334455667788; wbuf_strb[0] = 8'hFF;
        axi_write(32'h40, 4'd7, 4'd0, 1, br, bi, tmo);
        total++;
        if (tmo || br !== 2'b00 || bi !== 4'd7) begin
            bad++;
            $display("FAIL wr_b: tmo=%0d bresp=%b bid=%0d want 0 00 7", tmo, br, bi);
        end
        axi_read(32'h40, 4'd3, 4'd0, 0, nrx, lat, st, al, tmo);
        total++;
        if (tmo || lat != Lat) begin
            bad++;
            $display("FAIL rd_latency: tmo=%0d latency=%0d want %0d", tmo, lat, Lat);
        end
        total++;
        if (nrx != 1 || rbuf_data[0] !== 64'h1122334455667788 || rbuf_last[0] !== 1'b1 ||
            rbuf_id[0] !== 4'd3 || rbuf_resp[0] !== 2'b00) begin
            bad++;
            $display("FAIL rd_beat: n=%0d data=%h last=%b id=%0d resp=%b want 1 1122334455667788 1 3 00",
                     nrx, rbuf_data[0], rbuf_last[0], rbuf_id[0], rbuf_resp[0]);
        end
    endtask

    task automatic test_backpressure();
        bit tmo, st, al; int nrx, lat;
        axi_read(32'h0, 4'd9, 4'd3, 1, nrx, lat, st, al, tmo);
        total++;
        if (tmo || nrx != 4 || !st || !al) begin
            bad++;
            $display("FAIL bp_protocol: tmo=%0d beats=%0d stable=%0d ar_ready_low=%0d want 0 4 1 1",
                     tmo, nrx, st, al);
        end
        for (int k = 0; k < 4 && k < nrx; k++) begin
            total++;
            if (rbuf_data[k] !== ref_mem[k] || rbuf_last[k] !== (k == 3) || rbuf_resp[k] !== 2'b00) begin
                bad++;
                $display("FAIL bp_beat%0d: data=%h last=%b resp=%b want %h %b 00",
                         k, rbuf_data[k], rbuf_last[k], rbuf_resp[k], ref_mem[k], (k == 3));
            end
        end
    endtask

    task automatic test_strobes();
        logic [1:0] br; logic [3:0] bi; bit tmo, st, al; int nrx, lat;
        wbuf_data[0] = '1; wbuf_strb[0] = 8'hFF;
        axi_write(32'(10 * 8), 4'd1, 4'd0, 1, br, bi, tmo);
        wbuf_data[0] = '0; wbuf_strb[0] = 8'h0F;
        axi_write(32'(10 * 8), 4'd2, 4'd0, 1, br, bi, tmo);
        axi_read(32'(10 * 8), 4'd4, 4'd0, 0, nrx, lat, st, al, tmo);
        total++;
        if (tmo || nrx != 1 || rbuf_data[0] !== 64'hFFFF_FFFF_0000_0000) begin
            bad++;
            $display("FAIL strobe: tmo=%0d data=%h want ffffffff00000000", tmo, rbuf_data[0]);
        end
    endtask

    task automatic test_errors();
        logic [1:0] br; logic [3:0] bi; bit tmo, st, al; int nrx, lat;
        axi_read(32'h1FF8, 4'd5, 4'd1, 0, nrx, lat, st, al, tmo);
        total++;
        if (tmo || nrx != 2 || rbuf_data[0] !== ref_mem[1023] || rbuf_resp[0] !== 2'b00 ||
            rbuf_data[1] !== 64'd0 || rbuf_resp[1] !== 2'b10 || rbuf_last[1] !== 1'b1) begin
            bad++;
            $display("FAIL rd_oob: n=%0d d0=%h r0=%b d1=%h r1=%b want 2 %h 00 0 10",
                     nrx, rbuf_data[0], rbuf_resp[0], rbuf_data[1], rbuf_resp[1], ref_mem[1023]);
        end
        for (int k = 0; k < 2; k++) begin wbuf_data[k] = {$urandom, $urandom}; wbuf_strb[k] = 8'hFF; end
        axi_write(32'(20 * 8), 4'd6, 4'd2, 2, br, bi, tmo);
        total++;
        if (tmo || br !== 2'b10 || bi !== 4'd6) begin
            bad++;
            $display("FAIL wr_early_last: tmo=%0d bresp=%b bid=%0d want 0 10 6", tmo, br, bi);
        end
        axi_write(32'(24 * 8), 4'd8, 4'd0, 2, br, bi, tmo);
        total++;
        if (tmo || br !== 2'b10) begin
            bad++;
            $display("FAIL wr_late_last: tmo=%0d bresp=%b want 0 10", tmo, br);
        end
        axi_write(32'h1FF8, 4'd10, 4'd1, 2, br, bi, tmo);
        total++;
        if (tmo || br !== 2'b10) begin
            bad++;
            $display("FAIL wr_oob: tmo=%0d bresp=%b want 0 10", tmo, br);
        end
        axi_read(32'(20 * 8), 4'd0, 4'd5, 2, nrx, lat, st, al, tmo);
        for (int k = 0; k < 6 && k < nrx; k++) begin
            total++;
            if (rbuf_data[k] !== ref_mem[20 + k]) begin
                bad++;
                $display("FAIL err_commit%0d: data=%h want %h", k, rbuf_data[k], ref_mem[20 + k]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] br; logic [3:0] bi, id, len; bit tmo, st, al, oob; int nrx, lat, base, idx;
        for (int it = 0; it < 25; it++) begin
            len = 4'($urandom_range(0, 15));
            base = ($urandom_range(0, 3) == 0) ? 1008 + $urandom_range(0, 20)
                                               : $urandom_range(0, 63 - int'(len));
            id = 4'($urandom);
            oob = 0;
            for (int k = 0; k <= int'(len); k++) begin
                wbuf_data[k] = {$urandom, $urandom}; wbuf_strb[k] = 8'($urandom);
                if (base + k >= Depth) oob = 1;
            end
            axi_write(32'(base * 8 + $urandom_range(0, 7)), id, len, int'(len) + 1, br, bi, tmo);
            total++;
            if (tmo || bi !== id || br !== (oob ? 2'b10 : 2'b00)) begin
                bad++;
                $display("FAIL rnd_b%0d: tmo=%0d bid=%0d bresp=%b want %0d %b",
                         it, tmo, bi, br, id, oob ? 2'b10 : 2'b00);
            end
            len = 4'($urandom_range(0, 15));
            base = ($urandom_range(0, 3) == 0) ? 1008 + $urandom_range(0, 20)
                                               : $urandom_range(0, 63 - int'(len));
            id = 4'($urandom);
            axi_read(32'(base * 8 + $urandom_range(0, 7)), id, len, 2, nrx, lat, st, al, tmo);
            total++;
            if (tmo || nrx != int'(len) + 1 || !st || !al || lat != Lat) begin
                bad++;
                $display("FAIL rnd_rproto%0d: tmo=%0d beats=%0d stable=%0d arlow=%0d lat=%0d want beats %0d",
                         it, tmo, nrx, st, al, lat, int'(len) + 1);
            end
            for (int k = 0; k < nrx && k < 16; k++) begin
                idx = base + k;
                total++;
                if (rbuf_data[k] !== ((idx < Depth) ? ref_mem[idx] : 64'd0) ||
                    rbuf_resp[k] !== ((idx < Depth) ? 2'b00 : 2'b10) ||
                    rbuf_last[k] !== (k == int'(len)) || rbuf_id[k] !== id) begin
                    bad++;
                    $display("FAIL rnd_r%0d_%0d: data=%h resp=%b last=%b id=%0d want %h %b %b %0d",
                             it, k, rbuf_data[k], rbuf_resp[k], rbuf_last[k], rbuf_id[k],
                             (idx < Depth) ? ref_mem[idx] : 64'd0,
                             (idx < Depth) ? 2'b00 : 2'b10, (k == int'(len)), id);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int g, seen;
        ar_valid = 1; ar_addr = 32'h0; ar_id = 4'd2; ar_len = 4'd3;
        @(negedge clk);
        ar_valid = 0;
        g = 0;
        while (!r_valid && g < 50) begin @(negedge clk); g++; end
        r_ready = 1;
        @(negedge clk);
        r_ready = 0;
        rst = 0;
        @(negedge clk);
        total++;
        if (g >= 50 || r_valid !== 1'b0 || ar_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: wait=%0d r_valid=%b ar_ready=%b want r_valid 0 ar_ready 0",
                     g, r_valid, ar_ready);
        end
        rst = 1;
        @(negedge clk);
        total++;
        if (ar_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_ready: ar_ready=%b want 1", ar_ready);
        end
        r_ready = 1; seen = 0;
        repeat (10) begin @(negedge clk); if (r_valid) seen++; end
        r_ready = 0;
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL rst_mid_stale: stale beats=%0d want 0", seen);
        end
    endtask

    task automatic test_collision();
        logic [63:0] old_v, new_v;
        logic [1:0] br; logic [3:0] bi; bit tmo, st, al; int nrx, lat, g;
        old_v = ref_mem[5];
        new_v = {$urandom, $urandom};
        ar_valid = 1; ar_addr = 32'(5 * 8); ar_id = 4'd12; ar_len = 4'd0;
        aw_valid = 1; aw_addr = 32'(5 * 8); aw_id = 4'd13; aw_len = 4'd0;
        total++;
        if (ar_ready !== 1'b1 || aw_ready !== 1'b1) begin
            bad++;
            $display("FAIL col_ready: ar_ready=%b aw_ready=%b want 1 1", ar_ready, aw_ready);
        end
        @(negedge clk);
        ar_valid = 0; aw_valid = 0;
        // Land the W beat on the same edge that first presents the read beat.
        repeat (Lat - 1) @(negedge clk);
        w_valid = 1; w_data = new_v; w_strb = 8'hFF; w_last = 1;
        @(negedge clk);
        w_valid = 0; w_last = 0;
        ref_mem[5] = new_v;
        b_ready = 1; g = 0;
        while (!b_valid && g < 50) begin @(negedge clk); g++; end
        br = b_resp; bi = b_id;
        total++;
        if (g >= 50 || br !== 2'b00 || bi !== 4'd13 || r_valid !== 1'b1) begin
            bad++;
            $display("FAIL col_b: wait=%0d bresp=%b bid=%0d r_valid=%b want 00 13 1",
                     g, br, bi, r_valid);
        end
        @(negedge clk);
        b_ready = 0;
        r_ready = 1;
        total++;
        if (r_valid !== 1'b1 || r_data !== old_v || r_id !== 4'd12) begin
            bad++;
            $display("FAIL col_old: r_valid=%b data=%h id=%0d want 1 %h 12", r_valid, r_data, r_id, old_v);
        end
        @(negedge clk);
        r_ready = 0;
        axi_read(32'(5 * 8), 4'd1, 4'd0, 0, nrx, lat, st, al, tmo);
        total++;
        if (tmo || rbuf_data[0] !== new_v) begin
            bad++;
            $display("FAIL col_new: tmo=%0d data=%h want %h", tmo, rbuf_data[0], new_v);
        end
    endtask

    initial begin
        rst = 0;
        ar_valid = 0; ar_addr = '0; ar_id = '0; ar_len = '0; r_ready = 0;
        aw_valid = 0; aw_addr = '0; aw_id = '0; aw_len = '0;
        w_valid = 0; w_data = '0; w_strb = '0; w_last = 0; b_ready = 0;
        @(negedge clk);
        test_reset();
        test_init();
        test_write_read();
        test_backpressure();
        test_strobes();
        test_errors();
        test_random();
        test_reset_mid();
        test_collision();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
